dmem_responder: RTL

Memory-side responder for the MEM stage's data-memory request interface. It accepts one load/store request at a time, models a configurable access latency, and performs big-endian byte, halfword and word accesses with sign or zero extension. While an access is in flight it drives busy back to the pipeline; busy is the MEM-stage reg_lock source. It sits between mem_stage and the data storage and replaces the zero-latency data memory.

---
 rtl/dmem_if.sv | 29 ++
 rtl/dmem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the MEM stage (master)
// and the memory-side responder (slave). Bit 0 is the MSB on every vector.
//
// Handshake: the master raises req_valid with req_write/req_addr/req_wdata/
// dmem_info stable and holds all of them until it observes resp_valid.
// The slave answers with exactly one resp_valid cycle per accepted request;
// resp_rdata and resp_err are meaningful only in that cycle and are 0
// otherwise. busy tells the pipeline to stall while a request is open.
interface dmem_if;
  logic        req_valid;
  logic        req_write;
  logic [0:31] req_addr;
  logic [0:31] req_wdata;
  logic [0:2]  dmem_info;
  logic        busy;
  logic        resp_valid;
  logic [0:31] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, dmem_info,
    input  busy, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, dmem_info,
    output busy, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for MEM-stage loads and stores. One request is
// handled at a time with a fixed access latency; accesses are big-endian
// byte/half/word with sign or zero extension of sub-word loads.
// Misaligned or illegal-size requests return an error without touching
// storage. state_o exposes the FSM state (0 IDLE, 1 WAIT, 2 RESP).
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_if.slave      bus,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Storage: one 32-bit word per entry, byte lane 0 in bits [0:7].
  logic [0:31] mem_q [2**ADDR_W];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Captured request.
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        off_q;
  logic [0:31]       wdata_q;
  logic [1:0]        size_q;
  logic              zext_q;
  logic              write_q;

  // Registered response.
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [0:31]       resp_rdata_q, resp_rdata_d;

  logic              busy;
  logic              capture_en;
  logic              access;
  logic              mem_we;

  // Incoming request decode.
  logic [1:0]        req_size;
  logic [1:0]        req_off;
  logic              req_illegal;

  // Datapath helpers.
  logic [0:31]       rd_word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_val;
  logic [0:31]       store_word;
  logic [0:3]        lane_mask;

  // Address bits above the aliasing window are intentionally ignored.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[0:29-ADDR_W];

  // Classify the request on the bus: bad size or misaligned half/word.
  always_comb begin
    req_size    = bus.dmem_info[0:1];
    req_off     = bus.req_addr[30:31];
    req_illegal = 1'b0;
    if (req_size == 2'b11) begin
      req_illegal = 1'b1;
    end else if (req_size == SZ_HALF && req_off[0]) begin
      req_illegal = 1'b1;
    end else if (req_size == SZ_WORD && req_off != 2'b00) begin
      req_illegal = 1'b1;
    end
  end

  // Select the addressed lane(s) of the stored word and extend for loads.
  always_comb begin
    rd_word  = mem_q[idx_q];
    byte_v   = rd_word[{off_q, 3'b000} +: 8];
    half_v   = rd_word[{off_q[1], 4'b0000} +: 16];
    load_val = rd_word;
    case (size_q)
      SZ_BYTE: load_val = {{24{~zext_q & byte_v[7]}}, byte_v};
      SZ_HALF: load_val = {{16{~zext_q & half_v[15]}}, half_v};
      default: load_val = rd_word;
    endcase
  end

  // Replicate store data across lanes and build the lane write mask.
  always_comb begin
    store_word = wdata_q;
    lane_mask  = 4'b1111;
    case (size_q)
      SZ_BYTE: begin
        store_word = {4{wdata_q[24:31]}};
        lane_mask  = 4'b1000 >> off_q;
      end
      SZ_HALF: begin
        store_word = {2{wdata_q[16:31]}};
        lane_mask  = off_q[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        store_word = wdata_q;
        lane_mask  = 4'b1111;
      end
    endcase
  end

  // Next-state, counter, busy and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy         = 1'b0;
    capture_en   = 1'b0;
    access       = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        // Stall in the same cycle the request shows up.
        busy = bus.req_valid;
        if (bus.req_valid) begin
          capture_en = 1'b1;
          if (req_illegal) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access       = 1'b1;
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? 32'h0 : load_val;
        end
      end
      S_RESP: begin
        // req_valid here still belongs to the completed request.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_we = access & write_q;

  // FSM state, latency counter and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Latch the request fields when it is accepted from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      zext_q  <= 1'b0;
      write_q <= 1'b0;
    end else if (capture_en) begin
      idx_q   <= bus.req_addr[30-ADDR_W:29];
      off_q   <= bus.req_addr[30:31];
      wdata_q <= bus.req_wdata;
      size_q  <= bus.dmem_info[0:1];
      zext_q  <= bus.dmem_info[2];
      write_q <= bus.req_write;
    end
  end

  // Storage write on the access edge; unselected lanes keep their value.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_mask[l]) begin
          mem_q[idx_q][8*l +: 8] <= store_word[8*l +: 8];
        end
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign state_o        = state_q;

endmodule
